// File: rtl/kick_cmd_decoder_pkg.sv
// Shared kicker definitions: decoder states, level width, header byte.
// Also holds the packet checksum helper used by the decoder.
package kick_cmd_decoder_pkg;

  localparam int KICK_LEVEL_W = 7;

  localparam logic [KICK_LEVEL_W-1:0] KICK_FULL = 7'h7F;
  localparam logic [KICK_LEVEL_W-1:0] KICK_NONE = 7'h00;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_HDR = 2'd1,
    GOT_LVL = 2'd2
  } state_e;

  function automatic logic [7:0] kick_csum(
    input logic [7:0]              hdr,
    input logic [KICK_LEVEL_W-1:0] lvl
  );
    return hdr ^ {1'b0, lvl};
  endfunction

endpackage

// File: rtl/kick_hold_timer.sv
// Load/decrement/expire counter; expire_o pulses the cycle after it hits 0.
// Ports: clk, rst_n, load_i (reload to CYCLES), expire_o (one-cycle pulse).
module kick_hold_timer #(
  parameter int unsigned CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expire_q;
  logic             expire_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load_i) begin
      cnt_d = CNT_W'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CNT_W'(1);
      // last decrement: flag expiry for the next cycle
      expire_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/kick_cmd_decoder.sv
// Frames 3-byte kick packets (hdr, level, xor) from the rx byte stream.
// Ports: clk, rst_n, rx_valid/rx_data in; kick_level, kick_strobe, frame_err, busy out.
module kick_cmd_decoder
  import kick_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  HEADER         = DEFAULT_HEADER,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES    = 2500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic [KICK_LEVEL_W-1:0] kick_level,
  output logic                    kick_strobe,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                  state_q;
  logic [KICK_LEVEL_W-1:0] level_q;
  logic [TMO_W-1:0]        tmo_q;
  logic [KICK_LEVEL_W-1:0] kick_level_q;
  logic                    kick_strobe_q;
  logic                    frame_err_q;
  logic                    busy_q;

  logic accept_d;
  logic csum_ok_d;
  logic tmo_hit_d;
  logic hold_expire;

  assign csum_ok_d = (rx_data == kick_csum(HEADER, level_q));
  assign accept_d  = (state_q == GOT_LVL) && rx_valid && csum_ok_d;
  // counter holds the idle cycles still allowed; 1 means this is the last
  assign tmo_hit_d = (tmo_q <= TMO_W'(1));

  kick_hold_timer #(
    .CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept_d),
    .expire_o (hold_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      level_q       <= '0;
      tmo_q         <= '0;
      kick_level_q  <= '0;
      kick_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      kick_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
      // an accept below overrides this clear
      if (hold_expire) begin
        kick_level_q <= KICK_NONE;
      end
      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (rx_valid && rx_data == HEADER) begin
            state_q <= GOT_HDR;
            busy_q  <= 1'b1;
            tmo_q   <= TMO_W'(TIMEOUT_CYCLES);
          end
        end
        GOT_HDR: begin
          if (rx_valid) begin
            if (!rx_data[7]) begin
              level_q <= rx_data[KICK_LEVEL_W-1:0];
              state_q <= GOT_LVL;
              tmo_q   <= TMO_W'(TIMEOUT_CYCLES);
            end else begin
              frame_err_q <= 1'b1;
              if (rx_data == HEADER) begin
                // resync on a fresh header
                tmo_q <= TMO_W'(TIMEOUT_CYCLES);
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                tmo_q   <= '0;
              end
            end
          end else if (tmo_hit_d) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        GOT_LVL: begin
          if (rx_valid) begin
            if (csum_ok_d) begin
              kick_level_q  <= level_q;
              kick_strobe_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
          end else if (tmo_hit_d) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tmo_q   <= '0;
        end
      endcase
    end
  end

  assign kick_level  = kick_level_q;
  assign kick_strobe = kick_strobe_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_kick_cmd_decoder.sv
// Scoreboard bench for kick_cmd_decoder: directed packets, queued expectations.
// Monitor pops an expected event whenever strobe, frame_err or a level clear shows up.
module tb_kick_cmd_decoder;
  import kick_cmd_decoder_pkg::*;

  localparam int TMO  = 8;
  localparam int HOLD = 20;

  localparam int EV_STROBE = 0;
  localparam int EV_FERR   = 1;
  localparam int EV_CLEAR  = 2;

  typedef struct {
    int       kind;
    logic [6:0] lvl;
    int       stamp;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [6:0] kick_level;
  logic       kick_strobe;
  logic       frame_err;
  logic       busy;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  ev_t  exp_q[$];
  logic [6:0] prev_lvl;

  kick_cmd_decoder #(
    .HEADER         (8'hA5),
    .TIMEOUT_CYCLES (TMO),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .kick_level  (kick_level),
    .kick_strobe (kick_strobe),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [6:0] lvl, input int st);
    ev_t e;
    e.kind  = kind;
    e.lvl   = lvl;
    e.stamp = st;
    exp_q.push_back(e);
  endtask

  // drive at negedge; byte is sampled at the next posedge
  task automatic send(input logic [7:0] b, output int st);
    rx_valid = 1'b1;
    rx_data  = b;
    st       = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int left;
    left = budget;
    while (exp_q.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d events pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor
  always @(negedge clk) begin
    int  kind;
    bit  seen;
    ev_t e;
    if (!rst_n) begin
      prev_lvl = '0;
    end else begin
      seen = 1'b0;
      kind = EV_STROBE;
      if (kick_strobe && frame_err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL excl: strobe and frame_err both high at cyc %0d", cyc);
      end
      if (kick_strobe) begin
        seen = 1'b1;
        kind = EV_STROBE;
      end else if (frame_err) begin
        seen = 1'b1;
        kind = EV_FERR;
      end else if (kick_level == '0 && prev_lvl != '0) begin
        seen = 1'b1;
        kind = EV_CLEAR;
      end
      if (seen) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected: kind %0d lvl %0h at cyc %0d, want none",
                   kind, kick_level, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind || e.lvl != kick_level || e.stamp != cyc) begin
            n_bad++;
            $display("FAIL event: got kind %0d lvl %0h cyc %0d want kind %0d lvl %0h cyc %0d",
                     kind, kick_level, cyc, e.kind, e.lvl, e.stamp);
          end
        end
      end
      prev_lvl = kick_level;
    end
  end

  initial begin
    int st;
    int s1;
    int s2;
    logic [7:0] full;
    cyc      = 0;
    n_cmp    = 0;
    n_bad    = 0;
    prev_lvl = '0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    full     = {1'b0, KICK_FULL};

    idle(3);
    check("rst_level", kick_level, 0);
    check("rst_strobe", kick_strobe, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    idle(2);

    // good full-power packet, then hold expiry
    send(8'hA5, st);
    check("hdr_busy", busy, 1);
    idle(2);
    send(full, st);
    idle(2);
    send(8'hDA, st);
    push(EV_STROBE, 7'h7F, st);
    push(EV_CLEAR, 7'h00, st + HOLD + 1);
    check("good_level", kick_level, 'h7F);
    check("good_busy", busy, 0);
    drain("good", 60);
    check("good_cleared", kick_level, 0);

    // bad checksum
    send(8'hA5, st);
    send(8'h10, st);
    send(8'h00, st);
    push(EV_FERR, 7'h00, st);
    drain("badcs", 5);
    check("badcs_busy", busy, 0);
    check("badcs_level", kick_level, 0);

    // resync on a repeated header
    send(8'hA5, st);
    send(8'hA5, st);
    push(EV_FERR, 7'h00, st);
    check("resync_busy", busy, 1);
    send(8'h05, st);
    send(8'hA0, st);
    push(EV_STROBE, 7'h05, st);
    push(EV_CLEAR, 7'h00, st + HOLD + 1);
    drain("resync", 60);

    // inter-byte timeout
    send(8'hA5, st);
    push(EV_FERR, 7'h00, st + TMO);
    idle(4);
    check("tmo_busy_mid", busy, 1);
    idle(5);
    drain("tmo", 10);
    check("tmo_busy", busy, 0);
    send(8'h22, st);
    send(8'hA5, st);
    send(8'h40, st);
    send(8'hE5, st);
    push(EV_STROBE, 7'h40, st);
    push(EV_CLEAR, 7'h00, st + HOLD + 1);
    drain("after_tmo", 60);

    // mid-hold override restarts the hold window
    send(8'hA5, s1);
    send(full, s1);
    send(8'hDA, s1);
    push(EV_STROBE, 7'h7F, s1);
    idle(3);
    send(8'hA5, s2);
    send(8'h01, s2);
    send(8'hA4, s2);
    push(EV_STROBE, 7'h01, s2);
    push(EV_CLEAR, 7'h00, s2 + HOLD + 1);
    idle(HOLD - 4);
    check("ovr_level", kick_level, 'h01);
    drain("override", 60);

    // async reset mid-packet during an active hold
    send(8'hA5, st);
    send(full, st);
    send(8'hDA, st);
    push(EV_STROBE, 7'h7F, st);
    send(8'hA5, st);
    send(8'h30, st);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", kick_level, 0);
    check("arst_strobe", kick_strobe, 0);
    check("arst_ferr", frame_err, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(8'h95, st);
    idle(5);
    check("post_rst_busy", busy, 0);
    check("post_rst_level", kick_level, 0);
    drain("final", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
